// File: rtl/ifft_frame_player.sv
// ifft_frame_player: captures one real IFFT frame from AXI-Stream into a ping-pong
// buffer (scaled, clipped to DAC width) and replays the active bank cyclically to a DAC.
// A newly captured frame becomes active only at a playback wrap, so a period never tears.
// Optional feature macro: IFFT_PLAYER_SAT_EN (saturate out-of-range samples and pulse clip;
// when undefined, samples are truncated to their low DAC_W bits and clip stays 0).
module ifft_frame_player #(
  parameter int unsigned IN_W       = 40,
  parameter int unsigned DAC_W      = 8,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned SHIFT      = 10,
  parameter bit          OFFSET_BIN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   s_tdata,
  input  logic [ADDR_W-1:0] s_tuser,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic              dac_en,
  input  logic [ADDR_W-1:0] phase_off,
  input  logic [ADDR_W-1:0] step,
  output logic [DAC_W-1:0]  dac_data,
  output logic              dac_valid,
  output logic              frame_err,
  output logic              clip
);

  localparam int unsigned MEM_DEPTH = 2**(ADDR_W + 1);
  // MSB mask doubles as the offset-binary flip and the idle (midscale) output value
  localparam logic [DAC_W-1:0] MSB_MASK = OFFSET_BIN ? {1'b1, {(DAC_W-1){1'b0}}} : '0;

  typedef enum logic {W_FILL, W_WAIT} wstate_t;

  wstate_t             r_state;
  wstate_t             w_state_nxt;
  logic                w_accept;
  logic                w_swap;
  logic                w_wrap;
  logic                w_carry;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic [ADDR_W-1:0]   w_raddr;

  logic                r_tready;
  logic                r_pending;
  logic                r_front_valid;
  logic                r_bank;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic                r_frame_err;
  logic                r_clip;

  logic [DAC_W-1:0]    r_mem [MEM_DEPTH];
  logic [DAC_W-1:0]    r_rd_data;
  logic                r_rd_vld;
  logic                r_rd_fv;
  logic [DAC_W-1:0]    r_dac_data;
  logic                r_dac_valid;

  logic signed [IN_W-1:0] w_shifted;
  logic [DAC_W-1:0]    w_sample_raw;
  logic [DAC_W-1:0]    w_sample;
  logic                w_clip;

  // Sample scaling: arithmetic shift, then saturate or truncate to DAC width
  assign w_shifted = $signed(s_tdata) >>> SHIFT;

`ifdef IFFT_PLAYER_SAT_EN
  localparam logic [DAC_W-1:0] SAT_MAX = {1'b0, {(DAC_W-1){1'b1}}};
  localparam logic [DAC_W-1:0] SAT_MIN = {1'b1, {(DAC_W-1){1'b0}}};
  logic w_in_range;
  // In range when all bits above the DAC sign bit replicate it
  assign w_in_range   = (&w_shifted[IN_W-1:DAC_W-1]) | (~|w_shifted[IN_W-1:DAC_W-1]);
  assign w_sample_raw = w_in_range ? w_shifted[DAC_W-1:0]
                                   : (w_shifted[IN_W-1] ? SAT_MIN : SAT_MAX);
  assign w_clip       = ~w_in_range;
`else
  logic w_unused;
  assign w_unused     = ^w_shifted[IN_W-1:DAC_W];
  assign w_sample_raw = w_shifted[DAC_W-1:0];
  assign w_clip       = 1'b0;
`endif

  assign w_sample = w_sample_raw ^ MSB_MASK;

  // Read pointer advance; a carry out of the add marks a playback wrap
  assign {w_carry, w_ptr_nxt} = {1'b0, r_rd_ptr} + {1'b0, step};
  assign w_wrap  = dac_en & w_carry;
  assign w_raddr = r_rd_ptr + phase_off;

  // Commit the pending frame immediately when nothing plays yet, otherwise at a wrap
  assign w_swap = r_pending & (~r_front_valid | w_wrap);

  // Write FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= W_FILL;
    else        r_state <= w_state_nxt;
  end

  // Write FSM next state and beat acceptance
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      W_FILL: begin
        w_accept = s_tvalid & r_tready;
        if (w_accept && s_tlast) w_state_nxt = W_WAIT;
      end
      W_WAIT: begin
        if (w_swap) w_state_nxt = W_FILL;
      end
      default: w_state_nxt = W_FILL;
    endcase
  end

  // Capture-side control: ready, pending/bank handshake, status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tready      <= 1'b0;
      r_pending     <= 1'b0;
      r_front_valid <= 1'b0;
      r_bank        <= 1'b0;
      r_frame_err   <= 1'b0;
      r_clip        <= 1'b0;
    end else begin
      r_tready    <= (w_state_nxt == W_FILL);
      r_frame_err <= w_accept & s_tlast & (s_tuser != {ADDR_W{1'b1}});
      r_clip      <= w_accept & w_clip;
      if (w_swap) begin
        r_bank        <= ~r_bank;
        r_pending     <= 1'b0;
        r_front_valid <= 1'b1;
      end else if (w_accept && s_tlast) begin
        r_pending     <= 1'b1;
      end
    end
  end

  // Playback read pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_rd_ptr <= '0;
    else if (dac_en) r_rd_ptr <= w_ptr_nxt;
  end

  // Ping-pong RAM: writes go to the back bank, reads come from the front bank
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[{~r_bank, s_tuser}] <= w_sample;
    if (dac_en)   r_rd_data <= r_mem[{r_bank, w_raddr}];
  end

  // Read pipeline: RAM stage then output register, two clocks after dac_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld    <= 1'b0;
      r_rd_fv     <= 1'b0;
      r_dac_data  <= MSB_MASK;
      r_dac_valid <= 1'b0;
    end else begin
      r_rd_vld    <= dac_en;
      if (dac_en) r_rd_fv <= r_front_valid;
      r_dac_valid <= r_rd_vld;
      if (r_rd_vld) r_dac_data <= r_rd_fv ? r_rd_data : MSB_MASK;
    end
  end

  assign s_tready  = r_tready;
  assign dac_data  = r_dac_data;
  assign dac_valid = r_dac_valid;
  assign frame_err = r_frame_err;
  assign clip      = r_clip;

endmodule
